mu0_debug_master: RTL and testbench
===================================

Name: mu0_debug_master

Overview:
- Debug-side bus initiator that drives the memory/peripheral block's second (debug) port and its breakpoint RAM port.
- Accepts byte-serial commands from the host link (valid/ready), performs word reads/writes and breakpoint set/clear/query, and returns byte responses.
- Sits between the host byte link (UART/USB bridge) and the dual-port memory.

Parameters:
- TIMEOUT, 1_000_000, max idle cycles between bytes of one command before abort (8MHz: 125ms).
- READ_LATENCY, 1, cycles from address driven to read data sampled; minimum 1.

Ports:
- Clk  in  1  8MHz system clock
- Reset  in  1  synchronous, active-high reset
- rx_data  in  8  command byte from host link
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted on edge where rx_valid&rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host link consumes byte on edge where tx_valid&tx_ready
- mem_address  out  12  debug-port address
- mem_write_data  out  16  debug-port write data
- mem_read_data  in  16  debug-port read data (RAM latched on negedge; peripherals combinational)
- mem_wen  out  1  debug-port write enable, active high
- bp_address  out  16  breakpoint RAM address
- bp_write_data  out  1  breakpoint bit to write
- bp_read_data  in  1  breakpoint bit read
- bp_wen  out  1  breakpoint write enable, active high
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; mem_wen=0, bp_wen=0, tx_valid=0, tx_data=0, mem_address=0, mem_write_data=0, bp_address=0, bp_write_data=0, timeout counter=0. rx_ready=0 while Reset high. Reset mid-command abandons it; no partial write; a pending response is dropped.
- Commands (bytes in order):
  - 0x01 READ: adr_hi, adr_lo → response 0x81, dat_hi, dat_lo.
  - 0x02 WRITE: adr_hi, adr_lo, dat_hi, dat_lo → response 0x82.
  - 0x03 BP_SET / 0x04 BP_CLR: adr_hi, adr_lo → response 0x83.
  - 0x05 BP_QUERY: adr_hi, adr_lo → response 0x85, then 0x00 or 0x01.
  - Any other opcode → response 0xEE; no further bytes consumed.
- Address: 12 bits = {adr_hi[3:0], adr_lo}; adr_hi[7:4] ignored. bp_address = {4'h0, address12}.
- States: IDLE → ADR_HI → ADR_LO → (DAT_HI → DAT_LO for WRITE) → EXEC_{READ|WRITE|BP_WR|BP_RD} → SEND → IDLE.
- rx_ready=1 only in IDLE, ADR_HI, ADR_LO, DAT_HI, DAT_LO. Bytes offered during EXEC/SEND are not accepted.
- mem_address/bp_address are registered on the edge accepting adr_lo. mem_write_data is registered on the edge accepting dat_lo.
- WRITE: mem_wen=1 for exactly one cycle, beginning on the edge after dat_lo is accepted; address and data stable for that whole cycle.
- BP_SET/BP_CLR: bp_wen=1 for exactly one cycle, with bp_write_data=1 or 0; same timing as WRITE.
- READ/BP_QUERY:
  - Wait READ_LATENCY cycles after the address registers.
  - Sample mem_read_data or bp_read_data on the following edge.
  - Default: adr_lo accepted at edge E, data sampled at edge E+1.
- SEND:
  - Response bytes loaded into a 1–3 byte buffer; tx_valid rises on the edge entering SEND.
  - tx_data/tx_valid held stable until tx_ready; next byte presented the cycle after each handshake.
  - Return to IDLE on the edge where the last byte is handshaken.
  - No timeout in SEND.
- Timeout:
  - Counter clears on every accepted byte and in IDLE; counts in ADR_*/DAT_* states.
  - On reaching TIMEOUT, abort to SEND with the single byte 0xEF; no memory or breakpoint write issued.
- mem_wen and bp_wen are never high simultaneously and never high outside EXEC.

Decomposition:
- Package mu0_debug_pkg: opcode constants (0x01–0x05), response codes (0x81, 0x82, 0x83, 0x85, 0xEE, 0xEF), state enum.
- Sub-module mu0_debug_tx_buffer: 3-byte load/shift buffer with byte count and valid/ready output handshake.

Test Plan:
- Reset, then send 01 0F F0 with memory holding 0x1234 at 0xFF0 → mem_address=0xFF0; response 81 12 34; mem_wen never asserted.
- Send 02 00 10 AB CD → mem_wen high exactly one cycle with mem_address=0x010, mem_write_data=0xABCD; response 82.
- Send 03 01 23, then 05 01 23 → bp_wen one cycle with bp_address=0x0123, bp_write_data=1; responses 83, then 85 01. Send 04 01 23 then 05 01 23 → 83, then 85 00.
- Send opcode 0x7F → immediate 0xEE; next byte 01 is treated as a new opcode.
- Send 02 00 10 then stall TIMEOUT cycles → response EF, no mem_wen. Separately, hold tx_ready=0 for 50 cycles during a READ response → tx_data stable, rx_ready=0 throughout.
- Assert Reset in the cycle after dat_lo is accepted → mem_wen stays 0, tx_valid=0, state IDLE.

Source files
------------

// File: rtl/mu0_debug_pkg.sv
// Shared constants and types for the MU0 debug bus initiator.
package mu0_debug_pkg;

    // Host command opcodes
    localparam logic [7:0] OP_READ     = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_BP_SET   = 8'h03;
    localparam logic [7:0] OP_BP_CLR   = 8'h04;
    localparam logic [7:0] OP_BP_QUERY = 8'h05;

    // Response leader bytes
    localparam logic [7:0] RSP_READ     = 8'h81;
    localparam logic [7:0] RSP_WRITE    = 8'h82;
    localparam logic [7:0] RSP_BP_WRITE = 8'h83;
    localparam logic [7:0] RSP_BP_QUERY = 8'h85;
    localparam logic [7:0] RSP_BAD_OP   = 8'hEE;
    localparam logic [7:0] RSP_TIMEOUT  = 8'hEF;

    typedef enum logic [3:0] {
        StIdle,
        StAdrHi,
        StAdrLo,
        StDatHi,
        StDatLo,
        StExecRead,
        StExecWrite,
        StExecBpWr,
        StExecBpRd,
        StSend
    } state_e;

    // True for opcodes that are followed by an address
    function automatic logic is_known_op(input logic [7:0] op);
        return (op >= OP_READ) && (op <= OP_BP_QUERY);
    endfunction

endpackage

// File: rtl/mu0_debug_tx_buffer.sv
// Response buffer: holds up to three bytes and hands them out one at a time
// over a valid/ready link, oldest byte in the top lane.
module mu0_debug_tx_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [1:0]  load_count,
    input  logic [23:0] load_bytes,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [23:0] bytes_q;
    logic [1:0]  count_q;

    // Load a fresh response, or shift out one byte per handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_q <= 24'h0;
            count_q <= 2'd0;
        end else if (load) begin
            bytes_q <= load_bytes;
            count_q <= load_count;
        end else if (tx_valid && tx_ready) begin
            bytes_q <= {bytes_q[15:0], 8'h00};
            count_q <= count_q - 2'd1;
        end
    end

    assign tx_data  = bytes_q[23:16];
    // A response pending at reset is dropped, so never offer it while reset is high
    assign tx_valid = !reset && (count_q != 2'd0);
    assign done     = tx_valid && tx_ready && (count_q == 2'd1);

endmodule

// File: rtl/mu0_debug_master.sv
// Debug-side bus initiator: decodes byte-serial host commands into word
// reads/writes on the memory debug port and breakpoint RAM accesses, and
// returns byte responses.
module mu0_debug_master
    import mu0_debug_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 1_000_000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [11:0] mem_address,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data,
    output logic        mem_wen,
    output logic [15:0] bp_address,
    output logic        bp_write_data,
    input  logic        bp_read_data,
    output logic        bp_wen,
    output logic        busy
);

    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LatW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [LatW-1:0]   LatLast   = LatW'(READ_LATENCY - 1);

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [LatW-1:0]    lat_q, lat_d;
    logic [7:0]         opcode_q;
    logic [3:0]         adr_hi_q;
    logic [7:0]         dat_hi_q;

    logic               rx_fire;
    logic               buf_load;
    logic [1:0]         buf_count;
    logic [23:0]        buf_bytes;
    logic               tx_done;

    assign rx_ready = !Reset && (state_q inside {StIdle, StAdrHi, StAdrLo, StDatHi, StDatLo});
    assign rx_fire  = rx_valid && rx_ready;

    // Write strobes are pure state decodes, suppressed while reset is asserted
    // so a reset landing on the execute cycle never lets a write through.
    assign mem_wen    = !Reset && (state_q == StExecWrite);
    assign bp_wen     = !Reset && (state_q == StExecBpWr);
    assign bp_address = {4'h0, mem_address};
    assign busy       = (state_q != StIdle);

    // State, idle timer and read-latency counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lat_q   <= lat_d;
        end
    end

    // Command fields captured on the edge that accepts each byte
    always_ff @(posedge Clk) begin
        if (Reset) begin
            opcode_q       <= 8'h00;
            adr_hi_q       <= 4'h0;
            dat_hi_q       <= 8'h00;
            mem_address    <= 12'h000;
            mem_write_data <= 16'h0000;
            bp_write_data  <= 1'b0;
        end else if (rx_fire) begin
            case (state_q)
                StIdle: begin
                    opcode_q <= rx_data;
                    if (rx_data == OP_BP_SET || rx_data == OP_BP_CLR) begin
                        bp_write_data <= (rx_data == OP_BP_SET);
                    end
                end
                StAdrHi: adr_hi_q       <= rx_data[3:0];
                StAdrLo: mem_address    <= {adr_hi_q, rx_data};
                StDatHi: dat_hi_q       <= rx_data;
                StDatLo: mem_write_data <= {dat_hi_q, rx_data};
                default: ;
            endcase
        end
    end

    // Next-state, timeout and response loading
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lat_d     = lat_q;
        buf_load  = 1'b0;
        buf_count = 2'd0;
        buf_bytes = 24'h0;

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (rx_fire) begin
                    if (is_known_op(rx_data)) begin
                        state_d = StAdrHi;
                    end else begin
                        buf_load  = 1'b1;
                        buf_count = 2'd1;
                        buf_bytes = {RSP_BAD_OP, 16'h0000};
                        state_d   = StSend;
                    end
                end
            end

            StAdrHi, StAdrLo, StDatHi, StDatLo: begin
                if (rx_fire) begin
                    timer_d = '0;
                    if (state_q == StAdrHi) begin
                        state_d = StAdrLo;
                    end else if (state_q == StDatHi) begin
                        state_d = StDatLo;
                    end else if (state_q == StDatLo) begin
                        state_d = StExecWrite;
                    end else begin
                        lat_d = '0;
                        if (opcode_q == OP_READ) begin
                            state_d = StExecRead;
                        end else if (opcode_q == OP_WRITE) begin
                            state_d = StDatHi;
                        end else if (opcode_q == OP_BP_QUERY) begin
                            state_d = StExecBpRd;
                        end else begin
                            state_d = StExecBpWr;
                        end
                    end
                end else if (timer_q == TimerLast) begin
                    // Host went quiet mid-command: abandon it without touching memory
                    buf_load  = 1'b1;
                    buf_count = 2'd1;
                    buf_bytes = {RSP_TIMEOUT, 16'h0000};
                    state_d   = StSend;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end

            StExecRead: begin
                if (lat_q == LatLast) begin
                    buf_load  = 1'b1;
                    buf_count = 2'd3;
                    buf_bytes = {RSP_READ, mem_read_data};
                    state_d   = StSend;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end

            StExecBpRd: begin
                if (lat_q == LatLast) begin
                    buf_load  = 1'b1;
                    buf_count = 2'd2;
                    buf_bytes = {RSP_BP_QUERY, 7'h00, bp_read_data, 8'h00};
                    state_d   = StSend;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end

            StExecWrite: begin
                buf_load  = 1'b1;
                buf_count = 2'd1;
                buf_bytes = {RSP_WRITE, 16'h0000};
                state_d   = StSend;
            end

            StExecBpWr: begin
                buf_load  = 1'b1;
                buf_count = 2'd1;
                buf_bytes = {RSP_BP_WRITE, 16'h0000};
                state_d   = StSend;
            end

            StSend: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    mu0_debug_tx_buffer u_tx_buffer (
        .clk        (Clk),
        .reset      (Reset),
        .load       (buf_load),
        .load_count (buf_count),
        .load_bytes (buf_bytes),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .done       (tx_done)
    );

endmodule

// File: tb/tb_mu0_debug_master.sv
// Bench for mu0_debug_master: directed command scenarios plus randomized
// command traffic, checked against a command-level reference model.
module tb_mu0_debug_master;

    localparam int unsigned T_OUT = 40;

    logic        Clk;
    logic        Reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [11:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;
    logic        mem_wen;
    logic [15:0] bp_address;
    logic        bp_write_data;
    logic        bp_read_data;
    logic        bp_wen;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    mu0_debug_master #(
        .TIMEOUT      (T_OUT),
        .READ_LATENCY (1)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_wen        (mem_wen),
        .bp_address     (bp_address),
        .bp_write_data  (bp_write_data),
        .bp_read_data   (bp_read_data),
        .bp_wen         (bp_wen),
        .busy           (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_word(input int a);
        if (a == 12'hFF0) return 16'h1234;
        return 16'((a * 40503) + 7);
    endfunction

    // Environment: debug-port memory and breakpoint RAM
    logic [15:0] env_mem [4096];
    bit          env_bp  [4096];
    bit          env_ready;

    assign mem_read_data = env_mem[mem_address];
    assign bp_read_data  = env_bp[bp_address[11:0]];

    always @(posedge Clk) begin
        if (!env_ready) begin
            for (int i = 0; i < 4096; i++) begin
                env_mem[i] <= init_word(i);
                env_bp[i]  <= 1'b0;
            end
            env_ready <= 1'b1;
        end else begin
            if (mem_wen) env_mem[mem_address] <= mem_write_data;
            if (bp_wen)  env_bp[bp_address[11:0]] <= bp_write_data;
        end
    end

    // Reference model: memory image and expected outputs per command
    logic [15:0] ref_mem [4096];
    bit          ref_bp  [4096];
    logic [7:0]  exp_tx  [$];
    logic [27:0] exp_wr  [$];
    logic [12:0] exp_bpw [$];
    logic [7:0]  rx_log  [$];
    int          wen_pulses = 0;
    int          bpw_pulses = 0;
    logic [27:0] last_wr;
    logic [12:0] last_bpw;
    bit          tx_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host link consumer with random backpressure
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Per-cycle compare of DUT outputs against the model's expectations
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         prev_mem_wen;
    bit         prev_bp_wen;

    always @(negedge Clk) begin
        if (Reset) begin
            prev_stall   = 1'b0;
            prev_mem_wen = 1'b0;
            prev_bp_wen  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_valid_held", tx_valid, 1'b1);
                check("tx_data_held", tx_data, prev_data);
            end
            if (tx_valid) begin
                check("send_rx_ready", rx_ready, 1'b0);
                check("send_busy", busy, 1'b1);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", tx_data, exp_tx.pop_front());
                end
                rx_log.push_back(tx_data);
            end
            if (mem_wen) begin
                wen_pulses++;
                last_wr = {mem_address, mem_write_data};
                check("mem_wen_pulse", prev_mem_wen, 1'b0);
                check("wen_exclusive", bp_wen, 1'b0);
                check("mem_wen_busy", busy, 1'b1);
                if (exp_wr.size() == 0) check("mem_wen_unexpected", {4'h0, last_wr}, 32'hFFFF_FFFF);
                else check("mem_write", {4'h0, last_wr}, {4'h0, exp_wr.pop_front()});
            end
            if (bp_wen) begin
                bpw_pulses++;
                last_bpw = {bp_address[11:0], bp_write_data};
                check("bp_wen_pulse", prev_bp_wen, 1'b0);
                check("bp_addr_hi", bp_address[15:12], 4'h0);
                check("bp_wen_busy", busy, 1'b1);
                if (exp_bpw.size() == 0) check("bp_wen_unexpected", {19'h0, last_bpw}, 32'hFFFF_FFFF);
                else check("bp_write", {19'h0, last_bpw}, {19'h0, exp_bpw.pop_front()});
            end
            prev_stall   = tx_valid && !tx_ready;
            prev_data    = tx_data;
            prev_mem_wen = mem_wen;
            prev_bp_wen  = bp_wen;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge Clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (rx_ready) begin
                @(posedge Clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge Clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!ok) check("rx_accept", 32'd0, 32'd1);
    endtask

    // Apply one command and record what the specification says must follow
    task automatic run_cmd(input logic [7:0] op, input logic [11:0] adr, input logic [3:0] junk,
                           input logic [15:0] dat);
        case (op)
            8'h01: begin
                exp_tx.push_back(8'h81);
                exp_tx.push_back(ref_mem[adr][15:8]);
                exp_tx.push_back(ref_mem[adr][7:0]);
            end
            8'h02: begin
                ref_mem[adr] = dat;
                exp_wr.push_back({adr, dat});
                exp_tx.push_back(8'h82);
            end
            8'h03, 8'h04: begin
                ref_bp[adr] = (op == 8'h03);
                exp_bpw.push_back({adr, op == 8'h03});
                exp_tx.push_back(8'h83);
            end
            8'h05: begin
                exp_tx.push_back(8'h85);
                exp_tx.push_back({7'h00, ref_bp[adr]});
            end
            default: exp_tx.push_back(8'hEE);
        endcase
        send_byte(op);
        if (op >= 8'h01 && op <= 8'h05) begin
            send_byte({junk, adr[11:8]});
            send_byte(adr[7:0]);
            if (op == 8'h02) begin
                send_byte(dat[15:8]);
                send_byte(dat[7:0]);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_tx.size() == 0 && !busy) break;
            @(posedge Clk);
            #1;
        end
        check("drain_done", {31'h0, (exp_tx.size() != 0) || busy}, 32'd0);
    endtask

    task automatic expect_log(input string name, input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] want [3];
        want[0] = b0;
        want[1] = b1;
        want[2] = b2;
        check({name, "_len"}, rx_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_log.size()) check(name, rx_log[i], want[i]);
        end
        rx_log.delete();
    endtask

    initial begin
        int k;
        int w0;
        int b0;
        logic [7:0]  op;
        logic [11:0] adr;

        Reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_hold  = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = init_word(i);
            ref_bp[i]  = 1'b0;
        end

        repeat (3) @(posedge Clk);
        #1;
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_bp_wen", bp_wen, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_address", mem_address, 12'h000);
        check("rst_mem_write_data", mem_write_data, 16'h0000);
        check("rst_bp_address", bp_address, 16'h0000);
        check("rst_bp_write_data", bp_write_data, 1'b0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("idle_rx_ready", rx_ready, 1'b1);

        // READ 0xFF0 holding 0x1234
        w0 = wen_pulses;
        run_cmd(8'h01, 12'hFF0, 4'h0, 16'h0);
        check("read_address", mem_address, 12'hFF0);
        drain();
        expect_log("read_ff0", 3, 8'h81, 8'h12, 8'h34);
        check("read_no_wen", wen_pulses - w0, 0);

        // WRITE 0xABCD to 0x010
        w0 = wen_pulses;
        run_cmd(8'h02, 12'h010, 4'h0, 16'hABCD);
        drain();
        expect_log("write_010", 1, 8'h82, 8'h00, 8'h00);
        check("write_one_pulse", wen_pulses - w0, 1);
        check("write_strobe", {4'h0, last_wr}, {4'h0, 12'h010, 16'hABCD});

        // Breakpoint set / query / clear / query
        b0 = bpw_pulses;
        run_cmd(8'h03, 12'h123, 4'h0, 16'h0);
        drain();
        expect_log("bp_set", 1, 8'h83, 8'h00, 8'h00);
        check("bp_set_strobe", {19'h0, last_bpw}, {19'h0, 12'h123, 1'b1});
        run_cmd(8'h05, 12'h123, 4'h0, 16'h0);
        drain();
        expect_log("bp_query_set", 2, 8'h85, 8'h01, 8'h00);
        run_cmd(8'h04, 12'h123, 4'h0, 16'h0);
        drain();
        expect_log("bp_clr", 1, 8'h83, 8'h00, 8'h00);
        check("bp_clr_strobe", {19'h0, last_bpw}, {19'h0, 12'h123, 1'b0});
        run_cmd(8'h05, 12'h123, 4'hA, 16'h0);
        drain();
        expect_log("bp_query_clr", 2, 8'h85, 8'h00, 8'h00);
        check("bp_pulses", bpw_pulses - b0, 2);

        // Unknown opcode, then a read as a fresh command
        run_cmd(8'h7F, 12'h000, 4'h0, 16'h0);
        drain();
        expect_log("bad_op", 1, 8'hEE, 8'h00, 8'h00);
        run_cmd(8'h01, 12'h010, 4'h5, 16'h0);
        drain();
        expect_log("read_after_bad", 3, 8'h81, 8'hAB, 8'hCD);

        // Timeout mid-WRITE
        w0 = wen_pulses;
        exp_tx.push_back(8'hEF);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h10);
        k = 0;
        while (!tx_valid && k < 200) begin
            @(posedge Clk);
            #1;
            k++;
        end
        check("timeout_cycles", k, T_OUT);
        drain();
        expect_log("timeout", 1, 8'hEF, 8'h00, 8'h00);
        check("timeout_no_wen", wen_pulses - w0, 0);

        // Host stalls a READ response for 50 cycles
        tx_hold = 1'b1;
        run_cmd(8'h01, 12'hFF0, 4'h0, 16'h0);
        k = 0;
        while (!tx_valid && k < 20) begin
            @(posedge Clk);
            #1;
            k++;
        end
        for (int i = 0; i < 50; i++) begin
            check("hold_tx_valid", tx_valid, 1'b1);
            check("hold_tx_data", tx_data, 8'h81);
            check("hold_rx_ready", rx_ready, 1'b0);
            @(posedge Clk);
            #1;
        end
        tx_hold = 1'b0;
        drain();
        expect_log("read_held", 3, 8'h81, 8'h12, 8'h34);

        // Reset in the cycle after dat_lo is accepted
        w0 = wen_pulses;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h11);
        send_byte(8'h22);
        Reset = 1'b1;
        @(negedge Clk);
        check("rstmid_mem_wen", mem_wen, 1'b0);
        check("rstmid_tx_valid", tx_valid, 1'b0);
        @(posedge Clk);
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_mem_wen2", mem_wen, 1'b0);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rstmid_idle", busy, 1'b0);
        check("rstmid_no_tx", tx_valid, 1'b0);
        check("rstmid_mem_kept", env_mem[12'h020], init_word(12'h020));
        check("rstmid_no_pulse", wen_pulses - w0, 0);
        rx_log.delete();

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 11);
            if (k < 3) op = 8'h01;
            else if (k < 6) op = 8'h02;
            else if (k == 6) op = 8'h03;
            else if (k == 7) op = 8'h04;
            else if (k < 10) op = 8'h05;
            else op = 8'($urandom_range(6, 255));
            adr = 12'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) adr = adr | 12'hFE0;
            run_cmd(op, adr, 4'($urandom_range(0, 15)), 16'($urandom));
        end
        drain();
        check("end_writes_left", exp_wr.size(), 0);
        check("end_bp_writes_left", exp_bpw.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
